// File: rtl/pwm_core.sv
// Left-aligned PWM generator: a free-running period counter plus a duty register
// that is only updated at the period boundary, so pulses are never truncated.
module pwm_core #(
    parameter longint unsigned PERIOD = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pwm_value,
    output logic        pwm_out
);

    localparam int CNT_W = (PERIOD <= 2) ? 1 : $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      duty;
    logic             wrap;

    assign wrap = (cnt == CNT_LAST);

    // High while the zero-extended count is below duty; duty >= PERIOD saturates high.
    function automatic logic high_phase(input logic [CNT_W-1:0] c, input logic [31:0] d);
        return (32'(c) < d);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            duty <= '0;
        end else if (wrap) begin
            cnt  <= '0;
            duty <= pwm_value;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign pwm_out = high_phase(cnt, duty);

endmodule

// File: tb/tb_pwm_core.sv
// Bench for pwm_core: per-period high/low run lengths checked against a queue of
// expected high times, plus a PERIOD=2 instance checked cycle by cycle.
module tb_pwm_core;

    localparam int P = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pwm_value = 32'd0;
    logic [31:0] pwm_value2 = 32'd0;
    logic        pwm_out;
    logic        pwm_out2;

    int n_checks = 0;
    int n_fail   = 0;
    int   exp_q[$];
    logic exp2_q[$];

    typedef struct {
        logic [31:0] value;
        int          exp_high;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    pwm_core #(.PERIOD(P)) dut (
        .clk(clk), .rst(rst), .pwm_value(pwm_value), .pwm_out(pwm_out)
    );

    pwm_core #(.PERIOD(2)) dut2 (
        .clk(clk), .rst(rst), .pwm_value(pwm_value2), .pwm_out(pwm_out2)
    );

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse one reset edge; afterwards the bench sits at count 0 of the first period.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("reset_out", pwm_out, 0);
        check("reset_out2", pwm_out2, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(0);
    endtask

    // Observe one full period of dut, compare against the queued expectation, and
    // queue the expected high time for the period that follows.
    task automatic run_period(input int chg_at, input logic [31:0] chg_val, input int exp_next);
        int   hi = 0;
        int   lo = 0;
        int   bad_shape = 0;
        int   exp_hi = 0;
        logic seen_low = 1'b0;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            exp_hi = exp_q.pop_front();
        end
        for (int i = 0; i < P; i++) begin
            if (i == chg_at) pwm_value = chg_val;
            if (i == 0 && exp_hi > 0 && pwm_out == 1'b0) bad_shape++;
            if (pwm_out) begin
                hi++;
                if (seen_low) bad_shape++;
            end else begin
                lo++;
                seen_low = 1'b1;
            end
            if (i == P - 1) exp_q.push_back(exp_next);
            tick();
        end
        check("high_run", hi, exp_hi);
        check("low_run", lo, P - exp_hi);
        check("left_aligned", bad_shape, 0);
    endtask

    initial begin
        vecs[0] = '{32'd90, 90};
        vecs[1] = '{32'd90, 90};
        vecs[2] = '{32'd0, 0};
        vecs[3] = '{32'd100, 100};
        vecs[4] = '{32'hFFFF_FFFF, 100};
        vecs[5] = '{32'd1, 1};
        vecs[6] = '{32'd99, 99};
        vecs[7] = '{32'd101, 100};
        vecs[8] = '{32'd90, 90};

        rst = 1'b1;
        pwm_value = 32'd90;
        tick();
        check("reset_hold_out", pwm_out, 0);
        do_reset();

        // Each entry's value is set at the start of a period and shows up one period later.
        foreach (vecs[k]) begin
            pwm_value = vecs[k].value;
            run_period(-1, 32'd0, vecs[k].exp_high);
        end
        run_period(-1, 32'd0, 90);

        // Mid-period request change must not disturb the running period.
        run_period(40, 32'd30, 30);
        run_period(-1, 32'd0, 30);
        pwm_value = 32'd90;
        run_period(-1, 32'd0, 90);

        // Reset in the middle of the high phase aborts the pulse.
        for (int i = 0; i < 50; i++) tick();
        check("pre_reset_high", pwm_out, 1);
        do_reset();
        run_period(-1, 32'd0, 90);
        run_period(-1, 32'd0, 90);

        // Reset on the wrap edge must win over the duty load.
        for (int i = 0; i < P - 1; i++) tick();
        pwm_value = 32'd50;
        do_reset();
        run_period(-1, 32'd0, 50);
        run_period(-1, 32'd0, 50);
        run_period(-1, 32'd0, 50);

        // Two-cycle period: one low period, then 1,0 alternation, then constant high.
        pwm_value2 = 32'd1;
        do_reset();
        exp2_q.push_back(1'b0);
        exp2_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            exp2_q.push_back(1'b1);
            exp2_q.push_back(1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            logic b;
            if (i == 10) begin
                pwm_value2 = 32'd2;
                exp2_q.push_back(1'b1);
                exp2_q.push_back(1'b0);
                for (int j = 0; j < 4; j++) exp2_q.push_back(1'b1);
            end
            if (exp2_q.size() == 0) begin
                check("sb2_empty", 1, 0);
            end else begin
                b = exp2_q.pop_front();
                check("p2_out", pwm_out2, b);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
